fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction prefetch queue between the fetch stage (PC register, PC+4 adder, PC source mux) and decode. Each cycle it accepts one {PC, instruction} pair from fetch and buffers up to DEPTH entries in a circular buffer. Decode drains it through a valid/ready handshake. A flush from branch/jump resolution empties the queue in one cycle so that no wrong-path instruction reaches decode.

## Interface
- DEPTH, 4: number of entries; power of two, at least 2.
- PTR_W, 2: pointer width, log2(DEPTH).

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- flush  input  1  discard all entries and any same-cycle push.
- in_valid  input  1  fetch presents a valid pair.
- in_ready  output  1  queue can accept a pair this cycle.
- in_pc  input  32  PC of the presented instruction.
- in_instr  input  32  instruction word.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  32  PC of the head entry.
- out_instr  output  32  instruction word of the head entry.
- out_pc_plus4  output  32  out_pc + 4.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH x 64-bit entry array, write pointer wr_ptr, read pointer rd_ptr, occupancy count. Pointers wrap from DEPTH-1 to 0.
- Status signals:
  - in_ready = (count != DEPTH). It does not depend on out_ready; there is no full-queue pass-through.
  - out_valid = (count != 0).
- Push: when in_valid && in_ready && !flush, the entry at wr_ptr is written and wr_ptr increments.
- Pop: when out_valid && out_ready && !flush, rd_ptr increments.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: unchanged; legal at any occupancy, including count==1 and, for the pop side, when full.
- Output data:
  - out_pc and out_instr are the entry at rd_ptr.
  - When out_valid==0 they hold the last array contents; the value is don't-care, but it must not be X after reset (the array is cleared on reset).
- out_pc_plus4: combinational out_pc + 32'd4, modulo 2^32; 32'hFFFFFFFC gives 32'h00000000.
- Flush (flush==1 at an edge):
  - wr_ptr, rd_ptr and count go to 0.
  - The same-cycle push and pop are both ignored.
  - Array contents need not be cleared.
- Reset (rst==0 at an edge):
  - Pointers and count go to 0 and every array entry goes to 0.
  - Reset takes priority over flush, push and pop.
  - Reset applied mid-operation drops all entries.
- Upstream protocol:
  - Fetch holds in_pc and in_instr stable while in_valid && !in_ready; this is the fetch stage's stall.
  - in_valid with in_ready==0 has no effect.
- Pop with count==0 is ignored (out_valid is 0, so no handshake occurs).

## Timing
- Reset values: in_ready=1, out_valid=0, count=0, out_pc=0, out_instr=0, out_pc_plus4=32'h00000004.
- Push latency: an entry pushed at edge N is visible on out_* with out_valid=1 from just after edge N. The first instruction reaches decode one cycle after fetch presents it.
- Pop: after a pop at edge N, the next entry, or out_valid=0, is presented just after edge N.
- in_ready:
  - Falls just after the edge at which count reaches DEPTH.
  - Rises just after the first pop from full.
- Flush: out_valid=0 and in_ready=1 from just after the flush edge. A push in the cycle after the flush is accepted normally.
- Paths: in_ready, out_valid, count and out_* are driven from registers only. out_pc_plus4 has one 32-bit adder after a register. There is no combinational path from in_* or out_ready to any output.

## Test plan
- Reset: hold rst=0 for 2 cycles, then release -> in_ready=1, out_valid=0, count=0, out_pc_plus4=32'h4.
- Fill and drain:
  - Stimulus: out_ready=0; push pc=0,4,8,12 with instr=32'hA0..A3.
  - After 4 pushes: count=4, in_ready=0; a fifth push (pc=16) is ignored.
  - Then out_ready=1: heads appear as 0/A0, 4/A1, 8/A2, 12/A3 on consecutive cycles, out_pc_plus4 = head PC + 4; out_valid=0 after the fourth pop.
- Simultaneous push and pop:
  - At count=1, push and pop every cycle for 10 cycles -> count stays 1 and the PC order is preserved.
  - Same at count=4 with pop only: count goes to 3 and in_ready=1 the next cycle.
- Wrap-around: stream 20 entries, pc=0..76 in steps of 4, with out_ready toggling every other cycle -> every PC emerges exactly once, in order, with no duplicates or losses across pointer wrap.
- Flush: with 3 entries queued, assert flush together with in_valid=1 (pc=32'h100) -> count=0 and out_valid=0 next cycle, pc=32'h100 never emerges; a push of pc=32'h200 next cycle emerges first.
- Reset mid-stream and PC wrap:
  - With count=2, rst=0 for one cycle -> count=0 and out_valid=0.
  - Then push pc=32'hFFFFFFFC -> out_pc_plus4=32'h00000000.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the prefetch queue and decode.
// The queue itself uses the slave modport; the fetch/decode side uses the master modport.
interface fetch_queue_if #(
    parameter int PTR_W = 2
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic [31:0]      out_pc_plus4;
    logic [PTR_W:0]   count;

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_pc_plus4, count
    );

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_pc_plus4, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: circular buffer of {PC, instruction} pairs between fetch and decode.
// A flush empties the queue in one cycle so no wrong-path instruction reaches decode.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.slave  q
);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [63:0]      mem_q [DEPTH];
    logic [63:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             in_ready_w;
    logic             out_valid_w;
    logic             push;
    logic             pop;
    logic [63:0]      head;

    // Status comes straight from the occupancy register, never from the inputs.
    assign in_ready_w  = (count_q != FULL);
    assign out_valid_w = (count_q != '0);

    assign push = q.in_valid  && in_ready_w  && !q.flush;
    assign pop  = q.out_ready && out_valid_w && !q.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is the natural overflow.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign mem_d[gi] = (push && (wr_ptr_q == PTR_W'(gi)))
                             ? {q.in_pc, q.in_instr} : mem_q[gi];
        end
    endgenerate

    // Entries are cleared on reset so the idle output data is never X.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign q.in_ready     = in_ready_w;
    assign q.out_valid    = out_valid_w;
    assign q.out_pc       = head[63:32];
    assign q.out_instr    = head[31:0];
    assign q.out_pc_plus4 = head[63:32] + 32'd4;
    assign q.count        = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table for fill/drain plus scoreboarded corner-case sequences.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;

    fetch_queue_if #(.PTR_W(PTR_W)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t sb[$];

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        ordy;
        int          cnt;
        logic        ir;
        logic        ov;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, check the head on a pop, advance, then check status.
    task automatic cycle(input logic fl, input logic iv, input logic [31:0] pc,
                         input logic [31:0] ins, input logic ordy);
        logic acc;
        logic pp;
        ent_t e;
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
        acc = iv && (sb.size() < DEPTH) && !fl;
        pp  = ordy && (sb.size() != 0) && !fl;
        if (pp) begin
            chk("head_pc",    bus.out_pc,       sb[0].pc);
            chk("head_instr", bus.out_instr,    sb[0].ins);
            chk("head_plus4", bus.out_pc_plus4, sb[0].pc + 32'd4);
            n_pops++;
            $display("pop  pc=%h instr=%h", bus.out_pc, bus.out_instr);
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (pp) e = sb.pop_front();
            if (acc) sb.push_back('{pc: pc, ins: ins});
        end
        @(posedge clk);
        @(negedge clk);
        chk("count",     32'(bus.count),     32'(sb.size()));
        chk("in_ready",  32'(bus.in_ready),  32'(sb.size() != DEPTH));
        chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic iv;
        logic acc;

        bus.flush = 0; bus.in_valid = 0; bus.in_pc = '0; bus.in_instr = '0; bus.out_ready = 0;

        // Fill to full, attempt an overflow push, then drain.
        tbl[0] = '{1'b0, 1'b1, 32'd0,  32'hA0, 1'b0, 1, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 32'd4,  32'hA1, 1'b0, 2, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 32'd8,  32'hA2, 1'b0, 3, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 32'd12, 32'hA3, 1'b0, 4, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 32'd16, 32'hA4, 1'b0, 4, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 32'd0,  32'h0,  1'b1, 3, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 32'd0,  32'h0,  1'b1, 2, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 32'd0,  32'h0,  1'b1, 1, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 32'd0,  32'h0,  1'b1, 0, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count",     32'(bus.count),     32'd0);
        chk("rst_out_pc",    bus.out_pc,         32'd0);
        chk("rst_out_instr", bus.out_instr,      32'd0);
        chk("rst_plus4",     bus.out_pc_plus4,   32'h4);
        $display("reset released");

        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].ins, tbl[i].ordy);
            chk("vec_count",     32'(bus.count),     32'(tbl[i].cnt));
            chk("vec_in_ready",  32'(bus.in_ready),  32'(tbl[i].ir));
            chk("vec_out_valid", 32'(bus.out_valid), 32'(tbl[i].ov));
            $display("vec %0d count=%0d in_ready=%0b out_valid=%0b", i, bus.count, bus.in_ready, bus.out_valid);
        end

        // Push and pop together at count==1.
        cycle(0, 1, 32'h40, 32'hB0, 0);
        for (int i = 1; i <= 10; i++) begin
            cycle(0, 1, 32'h40 + 32'(4 * i), 32'hB0 + 32'(i), 1);
            chk("pp_count1", 32'(bus.count), 32'd1);
        end
        cycle(0, 0, 32'h0, 32'h0, 1);

        // Full queue with push and pop requested: only the pop happens.
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 32'h80 + 32'(4 * i), 32'hC0 + 32'(i), 0);
        cycle(0, 1, 32'h90, 32'hC4, 1);
        chk("full_pop_count",    32'(bus.count),    32'd3);
        chk("full_pop_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 32'h0, 32'h0, 1);

        // Stream 20 entries across pointer wrap with decode ready every other cycle.
        n_pops = 0;
        idx = 0;
        for (int cyc = 0; cyc < 200 && (idx < 20 || sb.size() != 0); cyc++) begin
            iv  = (idx < 20);
            acc = iv && (sb.size() < DEPTH);
            cycle(0, iv, 32'(idx * 4), 32'hD00 + 32'(idx), (cyc % 2) == 0);
            if (acc) idx++;
        end
        chk("wrap_pops",    32'(n_pops), 32'd20);
        chk("wrap_pushed",  32'(idx),    32'd20);

        // Flush with a same-cycle push: that push must never emerge.
        for (int i = 0; i < 3; i++) cycle(0, 1, 32'hE0 + 32'(4 * i), 32'hE0 + 32'(i), 0);
        cycle(1, 1, 32'h100, 32'hF00, 1);
        chk("flush_count",     32'(bus.count),     32'd0);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_ready",  32'(bus.in_ready),  32'd1);
        cycle(0, 1, 32'h200, 32'hF01, 0);
        chk("post_flush_head", bus.out_pc, 32'h200);
        cycle(0, 0, 32'h0, 32'h0, 1);

        // Reset mid-stream, then PC wrap in the +4 adder.
        cycle(0, 1, 32'h300, 32'h1, 0);
        cycle(0, 1, 32'h304, 32'h2, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        chk("mid_rst_count",     32'(bus.count),     32'd0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_pc",    bus.out_pc,         32'd0);
        $display("mid-stream reset done");
        cycle(0, 1, 32'hFFFFFFFC, 32'hDEADBEEF, 0);
        chk("pc_wrap_plus4", bus.out_pc_plus4, 32'h0);
        cycle(0, 0, 32'h0, 32'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
